// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding and per-slot slice widths.
package dmem_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // Width of a slot index; never below one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side signals of the data-memory arbiter.
// The slave modport is the arbiter; the master modport is harts plus memory.
interface dmem_arbiter_if import dmem_arb_pkg::*; #(
  parameter int unsigned NUM_PORTS = 3
) ();

  logic [NUM_PORTS-1:0]        i_req_valid;
  logic [NUM_PORTS-1:0]        i_req_ren;
  logic [NUM_PORTS-1:0]        i_req_wen;
  logic [DATA_W*NUM_PORTS-1:0] i_req_addr;
  logic [DATA_W*NUM_PORTS-1:0] i_req_wdata;
  logic [MASK_W*NUM_PORTS-1:0] i_req_mask;
  logic [NUM_PORTS-1:0]        o_req_ready;
  logic [NUM_PORTS-1:0]        o_rsp_valid;
  logic                        o_rsp_err;
  logic [DATA_W-1:0]           o_rsp_rdata;
  logic [DATA_W-1:0]           o_mem_addr;
  logic [DATA_W-1:0]           o_mem_wdata;
  logic [MASK_W-1:0]           o_mem_mask;
  logic                        o_mem_ren;
  logic                        o_mem_wen;
  logic                        i_mem_ready;
  logic                        i_mem_valid;
  logic [DATA_W-1:0]           i_mem_rdata;

  modport slave (
    input  i_req_valid, i_req_ren, i_req_wen, i_req_addr, i_req_wdata, i_req_mask,
    input  i_mem_ready, i_mem_valid, i_mem_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_rdata,
    output o_mem_addr, o_mem_wdata, o_mem_mask, o_mem_ren, o_mem_wen
  );

  modport master (
    output i_req_valid, i_req_ren, i_req_wen, i_req_addr, i_req_wdata, i_req_mask,
    output i_mem_ready, i_mem_valid, i_mem_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_rdata,
    input  o_mem_addr, o_mem_wdata, o_mem_mask, o_mem_ren, o_mem_wen
  );

endinterface

// File: rtl/dmem_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid slot at or after ptr, wrapping.
module rr_picker #(
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned PTR_W     = 2
) (
  input  logic [NUM_PORTS-1:0] valid,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 any
);

  // Walk offsets ptr, ptr+1, ... and grant the first valid slot met.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        if (!any && valid[k] && (((32'(ptr) + i) % NUM_PORTS) == k)) begin
          grant[k] = 1'b1;
          any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_PORTS harts,
// one outstanding transaction at a time.
module dmem_arbiter import dmem_arb_pkg::*; #(
  parameter int unsigned NUM_PORTS = 3
) (
  input logic           i_clk,
  input logic           i_rst,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = ptr_width(NUM_PORTS);

  state_t              state;
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    owner;
  logic [DATA_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   mask_q;
  logic                ren_q;
  logic                wen_q;
  logic                err_pend;

  logic [NUM_PORTS-1:0] grant;
  logic                 any;
  logic [PTR_W-1:0]     gidx;
  logic [PTR_W-1:0]     ptr_nxt;
  logic [DATA_W-1:0]    addr_sel;
  logic [DATA_W-1:0]    wdata_sel;
  logic [MASK_W-1:0]    mask_sel;
  logic                 ren_sel;
  logic                 wen_sel;
  logic                 capture;

  rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_picker (
    .valid (bus.i_req_valid),
    .ptr   (ptr),
    .grant (grant),
    .any   (any)
  );

  // Mux the granted slot's request fields and compute the rotated pointer.
  always_comb begin
    gidx      = '0;
    addr_sel  = '0;
    wdata_sel = '0;
    mask_sel  = '0;
    ren_sel   = 1'b0;
    wen_sel   = 1'b0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (grant[k]) begin
        gidx      = PTR_W'(k);
        addr_sel  = bus.i_req_addr[k*DATA_W +: DATA_W];
        wdata_sel = bus.i_req_wdata[k*DATA_W +: DATA_W];
        mask_sel  = bus.i_req_mask[k*MASK_W +: MASK_W];
        ren_sel   = bus.i_req_ren[k];
        wen_sel   = bus.i_req_wen[k];
      end
    end
    ptr_nxt = (gidx == PTR_W'(NUM_PORTS - 1)) ? '0 : gidx + 1'b1;
    // The error-pulse cycle stays in IDLE but does not grant, keeping the
    // one-idle-cycle gap between transactions.
    capture = (state == S_IDLE) && !err_pend && any;
  end

  // FSM, pointer and latched request; illegal requests skip memory and
  // raise a one-cycle error pulse from IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      owner    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      err_pend <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          err_pend <= 1'b0;
          if (capture) begin
            owner   <= gidx;
            addr_q  <= addr_sel;
            wdata_q <= wdata_sel;
            mask_q  <= mask_sel;
            ren_q   <= ren_sel;
            wen_q   <= wen_sel;
            ptr     <= ptr_nxt;
            if (ren_sel ^ wen_sel) state <= S_ISSUE;
            else                   err_pend <= 1'b1;
          end
        end
        S_ISSUE: if (bus.i_mem_ready) state <= S_WAIT;
        S_WAIT:  if (bus.i_mem_valid) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode; every output is forced to zero while reset is held.
  always_comb begin
    bus.o_req_ready = '0;
    bus.o_rsp_valid = '0;
    bus.o_rsp_err   = 1'b0;
    bus.o_rsp_rdata = '0;
    bus.o_mem_addr  = '0;
    bus.o_mem_wdata = '0;
    bus.o_mem_mask  = '0;
    bus.o_mem_ren   = 1'b0;
    bus.o_mem_wen   = 1'b0;
    if (!i_rst) begin
      bus.o_mem_addr  = addr_q;
      bus.o_mem_wdata = wdata_q;
      bus.o_mem_mask  = mask_q;
      bus.o_mem_ren   = (state == S_ISSUE) && ren_q;
      bus.o_mem_wen   = (state == S_ISSUE) && wen_q;
      if ((state == S_IDLE) && !err_pend) bus.o_req_ready = grant;
      if (err_pend || ((state == S_WAIT) && bus.i_mem_valid)) begin
        for (int unsigned k = 0; k < NUM_PORTS; k++)
          bus.o_rsp_valid[k] = (owner == PTR_W'(k));
        bus.o_rsp_err = err_pend;
      end
      if ((state == S_WAIT) && bus.i_mem_valid && ren_q) bus.o_rsp_rdata = bus.i_mem_rdata;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Round-robin arbiter that shares one data-memory port among `NUM_PORTS` hart requesters in the three-core build. Each hart's load/store port connects to a requester slot. The arbiter captures one request, sequences it onto the shared memory port with a ready/valid handshake, and returns the read data or write acknowledgement to the owning hart. There is one outstanding transaction at a time.

## Interface
- `NUM_PORTS`, 3: number of requester slots; legal range 2–4.
- `i_clk` input 1: clock; all state changes on the rising edge.
- `i_rst` input 1: synchronous, active-high reset.
- `i_req_valid` input NUM_PORTS: per-slot request pending.
- `i_req_ren` input NUM_PORTS: per-slot read request.
- `i_req_wen` input NUM_PORTS: per-slot write request.
- `i_req_addr` input 32*NUM_PORTS: per-slot word-aligned address; slot k is bits [32k+31:32k].
- `i_req_wdata` input 32*NUM_PORTS: per-slot store data, already lane-shifted.
- `i_req_mask` input 4*NUM_PORTS: per-slot byte mask.
- `o_req_ready` output NUM_PORTS: one-hot grant; the request is captured on the edge where valid and ready are both 1.
- `o_rsp_valid` output NUM_PORTS: one-hot, single-cycle completion pulse.
- `o_rsp_err` output 1: qualifies `o_rsp_valid`; set for an illegal request.
- `o_rsp_rdata` output 32: response data, shared by all slots.
- `o_mem_addr`, `o_mem_wdata` output 32 each: to shared memory.
- `o_mem_mask` output 4: to shared memory.
- `o_mem_ren`, `o_mem_wen` output 1 each: to shared memory; never asserted together.
- `i_mem_ready` input 1: memory accepts the current request this cycle.
- `i_mem_valid` input 1: memory completion, for both reads and writes.
- `i_mem_rdata` input 32: read data, valid with `i_mem_valid`.

## Operation
- FSM states are IDLE, ISSUE, WAIT. Reset state is IDLE.
- **Priority pointer**
  - `ptr` is reset to 0.
  - In IDLE, the granted slot is the first valid slot searching ptr, ptr+1, … modulo NUM_PORTS.
  - On capture, `ptr` becomes (granted+1) mod NUM_PORTS. `ptr` changes on no other event.
- **IDLE**
  - `o_req_ready` is driven combinationally: only the granted bit is 1, and it is 1 only if that slot's valid is 1.
  - On capture, the arbiter latches the owner index, addr, wdata, mask, ren and wen.
  - Legal request (exactly one of ren/wen set): next state is ISSUE.
  - Illegal request (both or neither set): no memory traffic. The next cycle pulses `o_rsp_valid[owner]` with `o_rsp_err`=1 and rdata=0, then returns to IDLE.
- **ISSUE**
  - `o_mem_*` are driven from the latched registers; `o_mem_ren`/`o_mem_wen` are held until `i_mem_ready`.
  - On `i_mem_ready`, next state is WAIT.
  - All `o_req_ready` bits are 0.
- **WAIT**
  - All `o_mem_ren`/`o_mem_wen` are 0.
  - On `i_mem_valid`: `o_rsp_valid[owner]`=1 and `o_rsp_rdata`=`i_mem_rdata` for reads, 0 for writes, both combinational. `o_rsp_err`=0. Next state is IDLE.
- Outside WAIT, `i_mem_valid` is ignored.
- Requesters may change or drop `i_req_*` at any time before capture. After capture, their inputs are don't-care until their response.

## Timing
- **Reset**
  - While `i_rst`=1, every output is 0: ready, rsp_valid, rsp_err, rsp_rdata, mem_ren, mem_wen, mem_addr, mem_wdata, mem_mask.
  - An in-flight transaction is dropped and its response is never delivered. The memory shares `i_rst`.
- **Minimum latency**, zero-wait memory:
  - Request captured at edge 0.
  - ISSUE with ready in cycle 1.
  - `i_mem_valid` in cycle 2, so the response appears 2 cycles after capture.
- **Throughput:** one transaction per 3 cycles at best. IDLE always lasts at least one cycle between transactions.
- **Memory protocol:** the response arrives no earlier than the cycle after acceptance. Ready and valid in the same ISSUE cycle is a protocol violation and is not handled.
- **Simultaneous events:** all slots valid in the same cycle are served in strict rotation. No slot waits more than NUM_PORTS−1 transactions.
- **Stall:** if `i_mem_ready` stays 0 indefinitely, the FSM stays in ISSUE with stable outputs.

## Structure
- Shared package/header `dmem_arb_pkg` holds:
  - state encodings IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2
  - the per-slot slice-width constants (32, 4)
- One sub-module, `rr_picker`: combinational, inputs `valid[NUM_PORTS]` and `ptr`, outputs one-hot `grant` and `any`. It is reused later for the imem arbiter.
- Top level holds the FSM, pointer, latched request registers, and response muxing.

## Test plan
- Reset with slot 1 valid (read 0x100) and `i_rst` high → all outputs 0. After release: slot 1 is granted in the first IDLE cycle; the read of 0x100 appears on the mem port next cycle; mem returns 0xDEADBEEF → `o_rsp_valid`=3'b010, rdata 0xDEADBEEF.
- All three slots hold valid reads continuously with zero-wait memory → grants in order 0,1,2,0,1,2. Each response goes to the matching slot, spaced 3 cycles apart.
- Slot 2 issues a write: addr 0x2000, wdata 0xAB000000, mask 4'b1000. Memory holds `i_mem_ready` low for 4 cycles → `o_mem_wen` and fields stay stable for 5 ISSUE cycles. After `i_mem_valid` → `o_rsp_valid`=3'b100, rdata 0.
- Slot 0 sets both ren and wen → no `o_mem_ren`/`o_mem_wen`. The next cycle gives `o_rsp_valid`=3'b001 with `o_rsp_err`=1. `ptr` advances to 1.
- Assert `i_rst` during WAIT of a slot-0 read, then deliver a late `i_mem_valid` → no `o_rsp_valid`. After reset, `ptr`=0 and slot 0 is granted first.
- Slot 1 drops valid in IDLE before a grant while slot 2 is valid → slot 2 is granted and slot 1 receives no response.
